// File: rtl/mdl_reg_lfo.sv
// Host write port and LFO register bank feeding mdl_lfo.
// Asynchronous bus strobes are synchronized, then committed on the phi1 grid.
`timescale 1ns/1ps
module mdl_reg_lfo #(
  parameter int BUSY_CYCLES = 64
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  output logic       o_BUSY,
  output logic [7:0] o_TEST,
  output logic [7:0] o_LFRQ,
  output logic [6:0] o_AMD,
  output logic [6:0] o_PMD,
  output logic [1:0] o_CT,
  output logic [1:0] o_W,
  output logic       o_LFRQ_UPDATE_n
);
  localparam int CW = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYCLES);

  // strobe carried active-low so the sync chain idles high
  logic       wr_n;
  logic       wr_n_s1, wr_n_s2, wr_n_s3;
  logic       a0_s1, a0_s2;
  logic [7:0] d_s1, d_s2;
  logic       wr_evt;
  logic       tick;

  assign wr_n   = i_CS_n | i_WR_n;
  assign wr_evt = wr_n_s3 & ~wr_n_s2;
  assign tick   = ~i_phi1_NCEN_n;

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      wr_n_s1 <= 1'b1;
      wr_n_s2 <= 1'b1;
      wr_n_s3 <= 1'b1;
      a0_s1   <= 1'b0;
      a0_s2   <= 1'b0;
      d_s1    <= 8'h00;
      d_s2    <= 8'h00;
    end else begin
      wr_n_s1 <= wr_n;
      wr_n_s2 <= wr_n_s1;
      wr_n_s3 <= wr_n_s2;
      a0_s1   <= i_A0;
      a0_s2   <= a0_s1;
      d_s1    <= i_D;
      d_s2    <= d_s1;
    end
  end

  logic [7:0]    addr;
  logic [7:0]    pend_d;
  logic          pending;
  logic          start;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      addr    <= 8'h00;
      pend_d  <= 8'h00;
      pending <= 1'b0;
      start   <= 1'b0;
      cnt     <= '0;
      o_BUSY  <= 1'b0;
    end else begin
      start <= 1'b0;
      if (tick && pending)
        pending <= 1'b0;
      // pending only rises on the capture cycle, so a same-cycle tick never commits it
      if (wr_evt) begin
        if (!a0_s2)
          addr <= d_s2;
        else if (!o_BUSY) begin
          pend_d  <= d_s2;
          pending <= 1'b1;
          start   <= 1'b1;
        end
      end
      if (start) begin
        o_BUSY <= 1'b1;
        cnt    <= BUSY_LD;
      end else if (tick && cnt != '0)
        cnt <= cnt - 1'b1;
      else if (cnt == '0)
        o_BUSY <= 1'b0;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      o_TEST          <= 8'h00;
      o_LFRQ          <= 8'h00;
      o_AMD           <= 7'h00;
      o_PMD           <= 7'h00;
      o_CT            <= 2'b00;
      o_W             <= 2'b00;
      o_LFRQ_UPDATE_n <= 1'b1;
    end else if (tick) begin
      // an LFRQ commit on this tick overrides releasing the previous pulse
      o_LFRQ_UPDATE_n <= ~(pending && addr == 8'h18);
      if (pending) begin
        case (addr)
          8'h01: o_TEST <= pend_d;
          8'h18: o_LFRQ <= pend_d;
          8'h19: begin
            if (pend_d[7]) o_PMD <= pend_d[6:0];
            else           o_AMD <= pend_d[6:0];
          end
          8'h1B: begin
            o_CT <= pend_d[7:6];
            o_W  <= pend_d[1:0];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdl_reg_lfo.sv
// Scoreboard bench for mdl_reg_lfo: accepted writes queue expected register
// snapshots; a monitor pops one per busy period and checks commit, pulse and busy length.
`timescale 1ns/1ps
module tb_mdl_reg_lfo;
  localparam int BUSY = 64;
  localparam int TPER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncen = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] d = 8'h00;
  logic       busy, upd_n;
  logic [7:0] test_o, lfrq_o;
  logic [6:0] amd_o, pmd_o;
  logic [1:0] ct_o, w_o;

  mdl_reg_lfo #(.BUSY_CYCLES(BUSY)) dut (
    .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen), .i_CS_n(cs_n),
    .i_WR_n(wr_n), .i_A0(a0), .i_D(d), .o_BUSY(busy), .o_TEST(test_o),
    .o_LFRQ(lfrq_o), .o_AMD(amd_o), .o_PMD(pmd_o), .o_CT(ct_o), .o_W(w_o),
    .o_LFRQ_UPDATE_n(upd_n)
  );

  typedef struct packed {
    logic [7:0] test;
    logic [7:0] lfrq;
    logic [6:0] amd;
    logic [6:0] pmd;
    logic [1:0] ct;
    logic [1:0] w;
  } regs_t;

  typedef struct packed {
    regs_t r;
    logic  lfrq;
  } exp_t;

  exp_t  q[$];
  regs_t model = '0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    tick_en = 1'b0;
  bit    mon_en = 1'b0;
  bit    done = 1'b0;
  bit    have_acc = 1'b0;
  int    last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    ncen = !(tick_en && (cyc % TPER == 0));
  end

  function automatic regs_t now_regs();
    return regs_t'({test_o, lfrq_o, amd_o, pmd_o, ct_o, w_o});
  endfunction

  function automatic regs_t apply(regs_t r, logic [7:0] a, logic [7:0] v);
    case (a)
      8'h01: r.test = v;
      8'h18: r.lfrq = v;
      8'h19: if (v[7]) r.pmd = v[6:0]; else r.amd = v[6:0];
      8'h1B: begin r.ct = v[7:6]; r.w = v[1:0]; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] v, input int len);
    @(negedge clk);
    a0 = a; d = v; cs_n = 1'b0; wr_n = 1'b0;
    repeat (len) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // busy window from issue is about 4 + BUSY*TPER + 5 clocks; 300 keeps clear of it
  task automatic do_item(input logic [7:0] a, input logic [7:0] v, input bit lng, input int len);
    int dd;
    bit acc;
    repeat (lng ? $urandom_range(300, 340) : $urandom_range(5, 120)) @(negedge clk);
    bus_wr(1'b0, a, $urandom_range(1, 4));
    dd = cyc - last_acc;
    if (have_acc && dd >= 200 && dd < 300) repeat (300 - dd) @(negedge clk);
    acc = !have_acc || (cyc - last_acc) >= 300;
    if (acc) begin
      have_acc = 1'b1;
      last_acc = cyc;
      model = apply(model, a, v);
      q.push_back('{r: model, lfrq: (a == 8'h18)});
    end
    bus_wr(1'b1, v, len);
  endtask

  initial begin : mon
    int   st, tk, up, age;
    exp_t e;
    logic bq, t;
    st = 0; tk = 0; up = 0; age = 0; e = '0; bq = 1'b0;
    wait (mon_en);
    bq = busy;
    while (!done) begin
      @(posedge clk);
      t = !ncen;
      #1;
      if (st == 0 && busy && !bq) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_busy: got busy=1 want no accepted write (cyc %0d)", cyc);
        end else begin
          e = q.pop_front();
          st = 1; tk = 0; up = 0; age = 0;
        end
      end
      if (st == 1 && t) begin
        chk("commit_regs", now_regs(), e.r);
        st = 2;
      end
      if (st != 0) begin
        age++;
        if (t && bq) tk++;
        if (!upd_n) up++;
      end
      if (st == 2 && bq && !busy) begin
        chk("busy_ticks", tk, BUSY);
        chk("upd_low_clks", up, e.lfrq ? TPER : 0);
        st = 0;
      end
      if (st != 0 && age > 400) begin
        total++; bad++;
        $display("FAIL busy_timeout: got state=%0d after %0d clks want busy released", st, age);
        st = 0;
      end
      bq = busy;
    end
  end

  initial begin
    logic [7:0] da[7]  = '{8'h18, 8'h19, 8'h19, 8'h1B, 8'h1B, 8'h01, 8'h20};
    logic [7:0] dv[7]  = '{8'hF2, 8'h70, 8'hBE, 8'hC2, 8'h01, 8'h55, 8'hAA};
    bit         dl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int         dn[7]  = '{2, 3, 1, 2, 2, 50, 2};
    logic       bmax, umin;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd_n", upd_n, 1'b1);
    chk("rst_test", test_o, 8'h00);
    chk("rst_lfrq", lfrq_o, 8'h00);
    chk("rst_amd_pmd", {amd_o, pmd_o}, 14'h0);
    chk("rst_ct_w", {ct_o, w_o}, 4'h0);
    rst = 1'b0;

    // reset while a captured write is still waiting for a phi1 tick
    bus_wr(1'b0, 8'h18, 2);
    bus_wr(1'b1, 8'h10, 2);
    chk("pend_busy_set", busy, 1'b1);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    tick_en = 1'b1;
    bmax = 1'b0; umin = 1'b1;
    repeat (40) begin
      @(negedge clk);
      bmax |= busy;
      umin &= upd_n;
    end
    chk("pend_rst_lfrq", lfrq_o, 8'h00);
    chk("pend_rst_busy", bmax, 1'b0);
    chk("pend_rst_upd_n", umin, 1'b1);

    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) do_item(da[i], dv[i], dl[i], dn[i]);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 4))
        0: a = 8'h01;
        1: a = 8'h18;
        2: a = 8'h19;
        3: a = 8'h1B;
        default: a = 8'($urandom);
      endcase
      do_item(a, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(1, 8));
    end
    repeat (400) @(negedge clk);
    done = 1'b1;
    chk("queue_drained", q.size(), 0);
    chk("final_regs", now_regs(), model);
    chk("final_busy", busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
